// File: rtl/writeback_ctrl.sv
// MEM/WB pipeline latch with a one-cycle register-file write pulse, plus a
// per-register pending-write scoreboard (2-bit saturating counts, sticky error).
module writeback_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_aluresult,
  input  logic [WIDTH-1:0] mem_readdata,
  input  logic             stall,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             kill_valid,
  input  logic [4:0]       kill_rd,
  input  logic [4:0]       chk_rs,
  input  logic [4:0]       chk_rt,
  output logic             regwrite,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] writedata,
  output logic             busy_rs,
  output logic             busy_rt,
  output logic             sb_err
);

  logic             valid_q, valid_d;
  logic             capt_q, capt_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [1:0]       cnt_q [32];
  logic [1:0]       cnt_d [32];
  logic             err_q, err_d;

  // valid_q marks a latched instruction that actually writes a nonzero
  // register; capt_q marks the cycle right after a fresh capture, so a
  // stalled latch never pulses twice.
  always_comb begin
    valid_d = valid_q;
    capt_d  = 1'b0;
    rd_d    = rd_q;
    wd_d    = wd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = mem_valid && mem_regwrite && (mem_rd != '0);
      capt_d  = 1'b1;
      rd_d    = mem_rd;
      wd_d    = mem_memtoreg ? mem_readdata : mem_aluresult;
    end
  end

  assign regwrite  = capt_q & valid_q;
  assign rd        = rd_q;
  assign writedata = wd_q;
  assign sb_err    = err_q;

  always_comb begin
    logic [4:0] ri;
    logic       inc;
    logic [1:0] dn;
    logic [2:0] up;
    err_d    = err_q;
    cnt_d[0] = '0;
    ri       = '0;
    inc      = 1'b0;
    dn       = '0;
    up       = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      ri  = 5'(r);
      inc = issue_valid && (issue_rd == ri);
      dn  = {1'b0, regwrite && (rd_q == ri)} + {1'b0, kill_valid && (kill_rd == ri)};
      up  = {1'b0, cnt_q[ri]} + {2'b00, inc};
      // Net result of all three terms is clamped, not each term separately.
      if (up < {1'b0, dn}) begin
        cnt_d[ri] = '0;
        err_d     = 1'b1;
      end else if ((up - {1'b0, dn}) > 3'd3) begin
        cnt_d[ri] = 2'd3;
        err_d     = 1'b1;
      end else begin
        cnt_d[ri] = 2'(up - {1'b0, dn});
      end
    end
  end

  assign busy_rs = (chk_rs != '0) && (cnt_q[chk_rs] != '0);
  assign busy_rt = (chk_rt != '0) && (cnt_q[chk_rt] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      capt_q  <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      capt_q  <= capt_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed vector table, hand-written reset/error
// sequences, then random traffic against an integer-count reference model.
module tb_writeback_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_valid, mem_regwrite, mem_memtoreg;
  logic [4:0]   mem_rd;
  logic [W-1:0] mem_aluresult, mem_readdata;
  logic         stall, flush, issue_valid, kill_valid;
  logic [4:0]   issue_rd, kill_rd, chk_rs, chk_rt;
  logic         regwrite, busy_rs, busy_rt, sb_err;
  logic [4:0]   rd;
  logic [W-1:0] writedata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_rd(mem_rd), .mem_aluresult(mem_aluresult), .mem_readdata(mem_readdata),
    .stall(stall), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .chk_rs(chk_rs), .chk_rt(chk_rt),
    .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .busy_rs(busy_rs), .busy_rt(busy_rt), .sb_err(sb_err)
  );

  typedef struct {
    logic mv, mr, mtr; logic [4:0] mrd; logic [W-1:0] alu, rdat;
    logic st, fl, iv; logic [4:0] ird; logic kv; logic [4:0] krd, crs, crt;
    logic e_brs, e_brt, e_rw; logic [4:0] e_rd; logic [W-1:0] e_wd; logic e_err;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  int           m_cnt [32];
  int           m_rw, m_rd, m_err;
  logic [W-1:0] m_wd;

  function automatic vec_t mk(input int mv, mr, mtr, mrd, input logic [W-1:0] alu, rdat,
                              input int st, fl, iv, ird, kv, krd, crs, crt,
                              input int brs, brt, rw, erd, input logic [W-1:0] wd, input int err);
    vec_t v;
    v.mv = mv[0]; v.mr = mr[0]; v.mtr = mtr[0]; v.mrd = 5'(mrd);
    v.alu = alu; v.rdat = rdat; v.st = st[0]; v.fl = fl[0];
    v.iv = iv[0]; v.ird = 5'(ird); v.kv = kv[0]; v.krd = 5'(krd);
    v.crs = 5'(crs); v.crt = 5'(crt);
    v.e_brs = brs[0]; v.e_brt = brt[0]; v.e_rw = rw[0]; v.e_rd = 5'(erd);
    v.e_wd = wd; v.e_err = err[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_regwrite = 1'b0; mem_memtoreg = 1'b0; mem_rd = '0;
    mem_aluresult = '0; mem_readdata = '0; stall = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; kill_valid = 1'b0; kill_rd = '0;
    chk_rs = '0; chk_rt = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_rw = 0; m_rd = 0; m_wd = '0; m_err = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Inputs are already driven; busy is checked before the edge, the rest after.
  task automatic run_cycle(input logic ebrs, ebrt, erw, input logic [4:0] erd,
                           input logic [W-1:0] ewd, input logic eerr);
    #1;
    chk("busy_rs", W'(busy_rs), W'(ebrs));
    chk("busy_rt", W'(busy_rt), W'(ebrt));
    @(posedge clk);
    #1;
    chk("regwrite", W'(regwrite), W'(erw));
    chk("rd", W'(rd), W'(erd));
    chk("writedata", writedata, ewd);
    chk("sb_err", W'(sb_err), W'(eerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int mv, mr, mtr, mrd, st, fl, iv, ird, kv, krd, crs, crt, v;
    logic [W-1:0] alu, rdat;
    logic ebrs, ebrt;

    //         mv mr mtr rd alu           rdat          st fl iv ird kv krd crs crt | brs brt rw rd wd           err
    tbl.push_back(mk(1, 1, 0, 5, 32'h1234,     32'h0,        0, 0, 1, 5, 0, 0, 5, 0,   0, 0, 1, 5, 32'h1234,     0));
    tbl.push_back(mk(0, 1, 0, 5, 32'h1234,     32'h0,        0, 0, 0, 0, 0, 0, 5, 0,   1, 0, 0, 5, 32'h1234,     0));
    tbl.push_back(mk(1, 1, 0, 0, 32'hABCD,     32'h0,        0, 0, 1, 0, 0, 0, 0, 5,   0, 0, 0, 0, 32'hABCD,     0));
    tbl.push_back(mk(1, 1, 1, 9, 32'h0,        32'hDEADBEEF, 0, 0, 1, 9, 0, 0, 9, 0,   0, 0, 1, 9, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 0, 3, 32'h1111,     32'h0,        1, 0, 0, 0, 0, 0, 9, 0,   1, 0, 0, 9, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 0, 3, 32'h1111,     32'h0,        1, 0, 0, 0, 0, 0, 9, 0,   0, 0, 0, 9, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 0, 3, 32'h1111,     32'h0,        1, 0, 0, 0, 0, 0, 9, 0,   0, 0, 0, 9, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 0, 3, 32'h1111,     32'h0,        1, 1, 0, 0, 0, 0, 0, 9,   0, 0, 0, 9, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 0, 7, 32'h77,       32'h0,        0, 0, 1, 7, 0, 0, 7, 0,   0, 0, 1, 7, 32'h77,       0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 7, 0, 0, 7, 0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 7, 7, 0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 7, 0,   0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 3, 0, 0, 3, 0,   0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 3, 0, 0, 3, 0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 3, 0, 0, 3, 0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 3, 0, 0, 3, 0,   1, 0, 0, 0, 32'h0,        1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 3, 0,   1, 0, 0, 0, 32'h0,        1));

    idle_inputs();
    apply_reset();
    chk("reset_regwrite", W'(regwrite), W'(1'b0));
    chk("reset_sb_err", W'(sb_err), W'(1'b0));
    chk("reset_writedata", writedata, '0);

    foreach (tbl[i]) begin
      mem_valid = tbl[i].mv; mem_regwrite = tbl[i].mr; mem_memtoreg = tbl[i].mtr;
      mem_rd = tbl[i].mrd; mem_aluresult = tbl[i].alu; mem_readdata = tbl[i].rdat;
      stall = tbl[i].st; flush = tbl[i].fl; issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      kill_valid = tbl[i].kv; kill_rd = tbl[i].krd; chk_rs = tbl[i].crs; chk_rt = tbl[i].crt;
      run_cycle(tbl[i].e_brs, tbl[i].e_brt, tbl[i].e_rw, tbl[i].e_rd, tbl[i].e_wd, tbl[i].e_err);
    end

    // Underflow on kill, then reset in the middle of a pending write.
    apply_reset();
    kill_valid = 1'b1; kill_rd = 5'd4;
    run_cycle(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b1);
    kill_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd2; chk_rs = 5'd2;
    run_cycle(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b1);
    issue_valid = 1'b0; mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd2;
    mem_aluresult = 32'h22;
    run_cycle(1'b1, 1'b0, 1'b1, 5'd2, 32'h22, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_regwrite", W'(regwrite), W'(1'b0));
    chk("async_rst_sb_err", W'(sb_err), W'(1'b0));
    chk("async_rst_rd", W'(rd), W'(5'd0));
    chk("async_rst_writedata", writedata, '0);
    for (int r = 0; r < 32; r++) begin
      chk_rs = 5'(r); chk_rt = 5'(31 - r);
      #1;
      chk("async_rst_busy_rs", W'(busy_rs), W'(1'b0));
      chk("async_rst_busy_rt", W'(busy_rt), W'(1'b0));
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    chk_rs = 5'd2;
    run_cycle(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0);

    // Random traffic against the reference model, with periodic resets.
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 150 == 149) apply_reset();
      mv = int'($urandom % 4 != 0); mr = int'($urandom_range(1, 0)); mtr = int'($urandom_range(1, 0));
      mrd = int'($urandom % 8); alu = $urandom; rdat = $urandom;
      st = int'($urandom % 4 == 0); fl = int'($urandom % 8 == 0);
      iv = int'($urandom_range(1, 0)); ird = int'($urandom % 8);
      kv = int'($urandom % 6 == 0); krd = int'($urandom % 8);
      crs = int'($urandom % 8); crt = int'($urandom % 32);

      mem_valid = mv[0]; mem_regwrite = mr[0]; mem_memtoreg = mtr[0]; mem_rd = 5'(mrd);
      mem_aluresult = alu; mem_readdata = rdat; stall = st[0]; flush = fl[0];
      issue_valid = iv[0]; issue_rd = 5'(ird); kill_valid = kv[0]; kill_rd = 5'(krd);
      chk_rs = 5'(crs); chk_rt = 5'(crt);

      ebrs = (crs != 0) && (m_cnt[crs] != 0);
      ebrt = (crt != 0) && (m_cnt[crt] != 0);

      for (int r = 1; r < 32; r++) begin
        v = m_cnt[r];
        if (iv != 0 && ird == r) v = v + 1;
        if (m_rw != 0 && m_rd == r) v = v - 1;
        if (kv != 0 && krd == r) v = v - 1;
        if (v > 3) begin v = 3; m_err = 1; end
        if (v < 0) begin v = 0; m_err = 1; end
        m_cnt[r] = v;
      end
      if (fl != 0 || st != 0) begin
        m_rw = 0;
      end else begin
        m_rw = (mv != 0 && mr != 0 && mrd != 0) ? 1 : 0;
        m_rd = mrd;
        m_wd = (mtr != 0) ? rdat : alu;
      end

      run_cycle(ebrs, ebrt, m_rw[0], 5'(m_rd), m_wd, m_err[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_ctrl.md
WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, data width of writeback values.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low; ports SHALL be named clk and rst_n.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- mem_valid  in  1  MEM stage holds an instruction
- mem_regwrite  in  1  instruction writes a register
- mem_memtoreg  in  1  1 = select load data, 0 = select ALU result
- mem_rd  in  5  destination register
- mem_aluresult  in  WIDTH  ALU result
- mem_readdata  in  WIDTH  load data
- stall  in  1  hold MEM/WB latch
- flush  in  1  invalidate MEM/WB latch
- issue_valid  in  1  decode issues an instruction with a destination
- issue_rd  in  5  destination of the issued instruction
- kill_valid  in  1  an in-flight counted instruction is squashed
- kill_rd  in  5  destination of the squashed instruction
- chk_rs, chk_rt  in  5 each  source registers to check
- regwrite  out  1  register file write enable
- rd  out  5  register file write address
- writedata  out  WIDTH  register file write data
- busy_rs, busy_rt  out  1 each  source has a pending write
- sb_err  out  1  sticky scoreboard overflow/underflow

Function
REQ-004 On a rising edge with flush=1, the MEM/WB latch SHALL become invalid; flush SHALL override stall.
REQ-005 On a rising edge with flush=0 and stall=1, the latch SHALL hold its contents.
REQ-006 On a rising edge with flush=0 and stall=0, the latch SHALL capture mem_valid, mem_regwrite and mem_rd, and SHALL set writedata to mem_readdata if mem_memtoreg=1, else mem_aluresult.
REQ-007 regwrite SHALL be registered and high for exactly one cycle after each capture where mem_valid=1, mem_regwrite=1 and mem_rd!=0.
REQ-008 A held latch (stall) SHALL NOT re-assert regwrite; latency from MEM inputs to the regwrite pulse SHALL be one cycle.
REQ-009 rd and writedata SHALL remain stable while regwrite is high.
REQ-010 The scoreboard SHALL keep a 2-bit pending count per register 1..31; register 0 SHALL always read count 0.
REQ-011 Each edge SHALL update count[r] = count[r] + inc - dec_w - dec_k, where:
- inc = issue_valid and issue_rd==r
- dec_w = regwrite and rd==r
- dec_k = kill_valid and kill_rd==r
All three terms SHALL apply in the same cycle, including when they target the same register.
REQ-012 A result above 3 SHALL saturate count at 3 and set sb_err.
REQ-013 A result below 0 SHALL clamp count at 0 and set sb_err.
REQ-014 sb_err SHALL be sticky until reset.
REQ-015 busy_rs SHALL equal (count[chk_rs]!=0), combinationally from the current count, before that edge's update.
REQ-016 busy_rt SHALL follow the same rule as busy_rs, using chk_rt.
REQ-017 A chk register equal to 0 SHALL always report not busy.
REQ-018 issue_rd, kill_rd or mem_rd equal to 0 SHALL have no scoreboard effect and SHALL NOT raise sb_err.

Reset
REQ-019 rst_n low SHALL immediately clear the following, independent of clk:
- latch valid
- regwrite, rd, writedata, all counts, sb_err
REQ-020 Reset mid-operation SHALL discard any pending write; no regwrite pulse SHALL follow reset release without a new capture.

Verification
REQ-021 The bench SHALL cover these scenarios (stimulus -> required response):
- ALU path: mem_valid=1, regwrite=1, memtoreg=0, rd=5, aluresult=0x1234 -> next cycle regwrite=1, rd=5, writedata=0x00001234; following cycle regwrite=0.
- Load under stall: memtoreg=1, readdata=0xDEADBEEF, rd=9, stall held 3 cycles after capture -> exactly one regwrite pulse; writedata stays 0xDEADBEEF.
- Zero register: rd=0, regwrite=1 -> regwrite stays 0; issue_rd=0 -> no count change; chk_rs=0 -> busy_rs=0.
- Scoreboard same-cycle: count[7]=1, issue_rd=7 and regwrite fire for rd=7 in the same cycle -> count[7] stays 1; busy_rs=1 with chk_rs=7.
- Error paths: 4 issues to rd=3 -> count 3 and sb_err=1; kill_rd=4 at count 0 -> sb_err=1.
- Reset mid-operation: rst_n low with a write latched and count[2]=2 -> regwrite=0, busy=0 for all registers, sb_err=0 immediately.
